if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the five-stage pipelined CPU. Owns the program counter and issues one word fetch at a time to instruction memory over a request/response handshake. It presents each fetched instruction and its PC+4 to the IF/ID stage register. It also handles hazard-unit stalls and branch/jump redirects from later stages, discarding any in-flight fetch that a redirect makes stale.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: IF/ID must not consume this cycle.
- redirect_valid  in  1  branch/jump taken; PC must be replaced.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- imem_req  out  1  fetch request valid (combinational from state).
- imem_addr  out  32  fetch address (always equals pc).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- ins_out  out  32  instruction to IF/ID; 32'h0 (NOP) when invalid.
- pc_plus4_out  out  32  PC+4 of ins_out.
- ins_valid  out  1  ins_out holds a real instruction.

## Operation
- Registers: pc[31:0], state ∈ {REQ, WAIT, DISCARD}, output register {ins_out, pc_plus4_out, ins_valid}.
- Reset: pc=RESET_PC, state=REQ, ins_out=0, pc_plus4_out=0, ins_valid=0.
- out_free = !ins_valid || !stall, meaning the output is empty or is consumed at this edge.
- imem_req = (state==REQ) && out_free && !redirect_valid. imem_addr = pc at all times.
- Consumption: on an edge with ins_valid=1 and stall=0 and no new response, the output register goes to the bubble value (0, 0, 0). While stall=1, the output register holds.
- REQ: if imem_req && imem_ready, go to WAIT. imem_rvalid is ignored in REQ.
- WAIT: on imem_rvalid without a redirect:
  - ins_out<=imem_rdata, pc_plus4_out<=pc+4, ins_valid<=1.
  - pc<=pc+4, state<=REQ.
- DISCARD: on imem_rvalid, drop the data and go to REQ. Outputs are not touched.
- Redirect (redirect_valid=1) takes priority over everything except reset:
  - pc<={redirect_pc[31:2],2'b00}.
  - Output register flushed to (0, 0, 0) even if stall=1.
  - Next state: REQ→REQ; WAIT without rvalid→DISCARD; WAIT with rvalid→REQ (response dropped); DISCARD without rvalid→DISCARD; DISCARD with rvalid→REQ.
- At most one outstanding request. A request is issued only when the output will be free, so a response always finds the output register empty. No skid buffer exists.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.
- Reset mid-fetch: state returns to REQ. A late imem_rvalid is then ignored, because memory shares the reset.

## Timing
- First request: imem_req=1 with imem_addr=RESET_PC in the first cycle after reset deasserts, given stall=0.
- Latency: request accepted at edge N, imem_rvalid in cycle M>N, ins_valid=1 from cycle M+1. The next imem_req can be high in cycle M+1.
- Zero-wait memory (rvalid the cycle after accept) gives one instruction every 2 cycles.
- Redirect in cycle R:
  - ins_valid=0 in cycle R+1.
  - The first request to the target is in cycle R+1 if the state was REQ or WAIT-with-rvalid. Otherwise it is the cycle after the stale response is dropped.
- stall held for k cycles with ins_valid=1: outputs constant for k cycles and no new imem_req issued.

## Test plan
- Reset, stall=0, memory answers 1 cycle after accept with data=addr^32'hA5A5_0000: addresses 0,4,8 are requested; ins_valid pulses every 2nd cycle; pc_plus4_out = 4, 8, 12.
- stall=1 for 3 cycles while ins_valid=1 (ins_out=32'h2002_0005): output held 3 cycles with imem_req=0; after stall drops, the next request is to the following address.
- Redirect to 32'h0000_0043 in WAIT with memory latency 3: the stale response is dropped, the next imem_addr is 32'h0000_0040, and the old-path instruction never appears with ins_valid=1.
- redirect_valid and imem_rvalid in the same WAIT cycle: data dropped, state REQ, next imem_addr = target, ins_valid=0.
- RESET_PC=32'hFFFF_FFFC: the first fetch gives pc_plus4_out=0, and the next imem_addr is 0.
- reset asserted while in WAIT and then a late imem_rvalid: all outputs are 0, the late data is ignored, and imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus used by the fetch stage.
//   req    : fetch request valid (fetch stage -> memory)
//   addr   : word-aligned fetch address (fetch stage -> memory)
//   ready  : memory accepts the request this cycle (memory -> fetch stage)
//   rvalid : read data valid (memory -> fetch stage)
//   rdata  : read data (memory -> fetch stage)
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the program counter, keeps at most one
// fetch outstanding on the instruction-memory bus, and presents each
// fetched instruction with its PC+4 to the IF/ID stage register. Handles
// hazard stalls and branch/jump redirects, discarding a fetch that a
// redirect has made stale.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   stall           : IF/ID does not consume the output this cycle
//   redirect_valid  : replace the PC with redirect_pc (low two bits forced 0)
//   imem            : request/response bus to instruction memory (master side)
//   ins_out         : fetched instruction, 0 when not valid
//   pc_plus4_out    : PC+4 of ins_out, 0 when not valid
//   ins_valid       : ins_out holds a real instruction
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            ins_out,
  output logic [31:0]            pc_plus4_out,
  output logic                   ins_valid
);

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ins_reg;
  logic [31:0] pc_plus4_reg;
  logic        valid_reg;

  logic        out_free;
  logic [31:0] pc_inc;
  logic [31:0] redirect_target;

  assign pc_inc          = pc_reg + 32'd4;  // wraps modulo 2^32
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  // A request goes out only when the output register will be empty by the
  // time the response lands, so no skid buffer is needed.
  assign out_free  = !valid_reg || !stall;
  assign imem.req  = (state_reg == REQ) && out_free && !redirect_valid;
  assign imem.addr = pc_reg;

  assign ins_out      = ins_reg;
  assign pc_plus4_out = pc_plus4_reg;
  assign ins_valid    = valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      state_reg    <= REQ;
      ins_reg      <= 32'h0;
      pc_plus4_reg <= 32'h0;
      valid_reg    <= 1'b0;
    end else if (redirect_valid) begin
      // Flush wins over stall: the instruction in IF/ID is on the wrong path.
      pc_reg       <= redirect_target;
      ins_reg      <= 32'h0;
      pc_plus4_reg <= 32'h0;
      valid_reg    <= 1'b0;
      case (state_reg)
        REQ:     state_reg <= REQ;
        // An outstanding fetch must still be drained; if its response is
        // arriving right now it is simply dropped.
        WAIT,
        DISCARD: state_reg <= imem.rvalid ? REQ : DISCARD;
        default: state_reg <= REQ;
      endcase
    end else begin
      // Consumed output becomes a bubble unless a new response overwrites it.
      if (valid_reg && !stall) begin
        ins_reg      <= 32'h0;
        pc_plus4_reg <= 32'h0;
        valid_reg    <= 1'b0;
      end
      case (state_reg)
        REQ: begin
          if (imem.req && imem.ready) begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            ins_reg      <= imem.rdata;
            pc_plus4_reg <= pc_inc;
            valid_reg    <= 1'b1;
            pc_reg       <= pc_inc;
            state_reg    <= REQ;
          end
        end
        DISCARD: begin
          if (imem.rvalid) begin
            state_reg <= REQ;
          end
        end
        default: state_reg <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ins_out;
  logic [31:0] pc_plus4_out;
  logic        ins_valid;

  logic        reset_b;
  logic        stall_b;
  logic        redirect_valid_b;
  logic [31:0] redirect_pc_b;
  logic [31:0] ins_out_b;
  logic [31:0] pc_plus4_out_b;
  logic        ins_valid_b;

  if_fetch_stage_if bus_a ();
  if_fetch_stage_if bus_b ();

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus_a),
    .ins_out        (ins_out),
    .pc_plus4_out   (pc_plus4_out),
    .ins_valid      (ins_valid)
  );

  // Second instance exercising the PC wrap at the top of the address space.
  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .reset          (reset_b),
    .stall          (stall_b),
    .redirect_valid (redirect_valid_b),
    .redirect_pc    (redirect_pc_b),
    .imem           (bus_b),
    .ins_out        (ins_out_b),
    .pc_plus4_out   (pc_plus4_out_b),
    .ins_valid      (ins_valid_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected {ins_out, pc_plus4_out} pairs, pushed by stimulus.
  logic [63:0] sb_a[$];
  logic [63:0] sb_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  // Memory model contents: one fixed word, everything else addr ^ pattern.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h2002_0005;
    return a ^ 32'hA5A5_0000;
  endfunction

  int unsigned mem_lat;
  logic        pend_a, pend_b;
  int unsigned cnt_a, cnt_b;
  logic [31:0] addr_a, addr_b;

  // One clock cycle: sample acceptance late in the cycle, then after the
  // edge present any response due in the new cycle.
  task automatic step();
    #2;
    if (reset) pend_a = 1'b0;
    else if (bus_a.req && bus_a.ready) begin
      pend_a = 1'b1; cnt_a = mem_lat; addr_a = bus_a.addr;
    end
    if (reset_b) pend_b = 1'b0;
    else if (bus_b.req && bus_b.ready) begin
      pend_b = 1'b1; cnt_b = 1; addr_b = bus_b.addr;
    end
    @(posedge clk);
    #1;
    bus_a.rvalid = 1'b0;
    bus_a.rdata  = 32'h0;
    if (pend_a) begin
      cnt_a--;
      if (cnt_a == 0) begin
        bus_a.rvalid = 1'b1; bus_a.rdata = mem_data(addr_a); pend_a = 1'b0;
      end
    end
    bus_b.rvalid = 1'b0;
    bus_b.rdata  = 32'h0;
    if (pend_b) begin
      cnt_b--;
      if (cnt_b == 0) begin
        bus_b.rvalid = 1'b1; bus_b.rdata = mem_data(addr_b); pend_b = 1'b0;
      end
    end
  endtask

  // Monitor for the main instance: every newly presented instruction is
  // popped from the scoreboard; a held (stalled) output is not re-popped.
  logic held_a = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      held_a <= 1'b0;
    end else begin
      if (ins_valid && !held_a) begin
        if (sb_a.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_ins: got %h pc4 %h, expected none", ins_out, pc_plus4_out);
        end else begin
          logic [63:0] e;
          e = sb_a.pop_front();
          chk("mon_ins", ins_out, e[63:32]);
          chk("mon_pc4", pc_plus4_out, e[31:0]);
        end
      end
      held_a <= ins_valid && stall;
    end
  end

  always @(negedge clk) begin
    if (!reset_b && ins_valid_b) begin
      if (sb_b.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_ins_wrap: got %h pc4 %h, expected none", ins_out_b, pc_plus4_out_b);
      end else begin
        logic [63:0] e;
        e = sb_b.pop_front();
        chk("mon_wrap_ins", ins_out_b, e[63:32]);
        chk("mon_wrap_pc4", pc_plus4_out_b, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    reset_b = 1'b1; stall_b = 1'b0; redirect_valid_b = 1'b0; redirect_pc_b = 32'h0;
    bus_a.ready = 1'b1; bus_a.rvalid = 1'b0; bus_a.rdata = 32'h0;
    bus_b.ready = 1'b1; bus_b.rvalid = 1'b0; bus_b.rdata = 32'h0;
    mem_lat = 1; pend_a = 1'b0; pend_b = 1'b0;
    cnt_a = 0; cnt_b = 0; addr_a = 32'h0; addr_b = 32'h0;

    step();
    #1;
    chk("rst_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_ins", ins_out, 32'h0);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    chk("rst_addr", bus_a.addr, 32'h0);
    step();
    step();

    // Sequential fetch with zero-wait memory, then the stalled word at 0xC.
    sb_a.push_back({32'hA5A5_0000, 32'h0000_0004});
    sb_a.push_back({32'hA5A5_0004, 32'h0000_0008});
    sb_a.push_back({32'hA5A5_0008, 32'h0000_000C});
    sb_a.push_back({32'h2002_0005, 32'h0000_0010});
    sb_b.push_back({32'h5A5A_FFFC, 32'h0000_0000});
    sb_b.push_back({32'hA5A5_0000, 32'h0000_0004});

    reset = 1'b0; reset_b = 1'b0;          // cycle c0
    #1;
    chk("first_req", {31'h0, bus_a.req}, 32'h1);
    chk("first_addr", bus_a.addr, 32'h0);
    chk("wrap_first_addr", bus_b.addr, 32'hFFFF_FFFC);
    step(); step();                         // c2
    #1;
    chk("wrap_next_addr", bus_b.addr, 32'h0);
    step(); step(); step();                 // c5
    reset_b = 1'b1;
    step(); step(); step();                 // c8

    for (int k = 0; k < 3; k++) begin       // c8..c10 stalled
      stall = 1'b1;
      #1;
      chk("stall_req", {31'h0, bus_a.req}, 32'h0);
      chk("stall_valid", {31'h0, ins_valid}, 32'h1);
      chk("stall_ins", ins_out, 32'h2002_0005);
      chk("stall_pc4", pc_plus4_out, 32'h0000_0010);
      step();
    end
    stall = 1'b0;                           // c11
    mem_lat = 3;
    #1;
    chk("post_stall_req", {31'h0, bus_a.req}, 32'h1);
    chk("post_stall_addr", bus_a.addr, 32'h0000_0010);
    step();                                 // c12: WAIT, response 3 cycles out

    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    #1;
    chk("redir_req", {31'h0, bus_a.req}, 32'h0);
    step();                                 // c13: DISCARD
    redirect_valid = 1'b0;
    #1;
    chk("redir_valid", {31'h0, ins_valid}, 32'h0);
    chk("redir_addr", bus_a.addr, 32'h0000_0040);
    chk("discard_req", {31'h0, bus_a.req}, 32'h0);
    step();                                 // c14: stale response arrives
    #1;
    chk("discard_req2", {31'h0, bus_a.req}, 32'h0);
    step();                                 // c15
    #1;
    chk("target_req", {31'h0, bus_a.req}, 32'h1);
    chk("target_addr", bus_a.addr, 32'h0000_0040);
    sb_a.push_back({32'hA5A5_0040, 32'h0000_0044});
    mem_lat = 1;
    step(); step(); step();                 // c18: WAIT with rvalid for 0x44

    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    chk("redir_rv_rvalid", {31'h0, bus_a.rvalid}, 32'h1);
    step();                                 // c19
    redirect_valid = 1'b0;
    #1;
    chk("redir_rv_valid", {31'h0, ins_valid}, 32'h0);
    chk("redir_rv_req", {31'h0, bus_a.req}, 32'h1);
    chk("redir_rv_addr", bus_a.addr, 32'h0000_0100);
    sb_a.push_back({32'hA5A5_0100, 32'h0000_0104});
    step(); step();                         // c21
    mem_lat = 3;
    step();                                 // c22: WAIT for 0x104

    reset = 1'b1;
    step();                                 // c23
    reset = 1'b0;
    bus_a.rvalid = 1'b1; bus_a.rdata = 32'hDEAD_BEEF;  // late response
    #1;
    chk("mid_rst_valid", {31'h0, ins_valid}, 32'h0);
    chk("mid_rst_ins", ins_out, 32'h0);
    chk("mid_rst_pc4", pc_plus4_out, 32'h0);
    chk("mid_rst_addr", bus_a.addr, 32'h0);
    sb_a.push_back({32'hA5A5_0000, 32'h0000_0004});
    step();                                 // c24
    #1;
    chk("late_ignored_valid", {31'h0, ins_valid}, 32'h0);
    chk("late_ignored_addr", bus_a.addr, 32'h0);
    for (int k = 0; k < 5; k++) step();

    chk("sb_a_drained", sb_a.size(), 32'h0);
    chk("sb_b_drained", sb_b.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
